// File: rtl/spi_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_dbg_pkg
// Purpose  : Shared opcodes, frame/bus state encodings and the overrun fill
//            pattern for the SPI debug bridge.
// Revision : 1.0 - initial release
// ============================================================================
package spi_dbg_pkg;

    localparam logic [7:0] C_CMD_WRITE = 8'h02;
    localparam logic [7:0] C_CMD_READ  = 8'h03;
    localparam logic [7:0] C_CMD_HALT  = 8'h10;
    localparam logic [7:0] C_CMD_RUN   = 8'h11;
    localparam logic [7:0] C_OVERRUN   = 8'hEE;

    typedef enum logic [2:0] {
        F_IDLE   = 3'd0,
        F_ADDR_H = 3'd1,
        F_ADDR_L = 3'd2,
        F_WDATA  = 3'd3,
        F_DUMMY  = 3'd4,
        F_RDATA  = 3'd5,
        F_IGNORE = 3'd6
    } frame_state_t;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_REQ  = 2'd1,
        B_CYC  = 2'd2,
        B_CAP  = 2'd3
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_tgt_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_tgt_shifter
// Purpose  : SPI mode-0 target front end. Synchronises SCK/CS_N/MOSI into
//            the clk domain, detects SCK edges, assembles received bytes and
//            shifts transmit bytes out MSB first.
// Ports    : clk, reset (async, active low)
//            spi_sck/spi_cs_n/spi_mosi - raw SPI inputs
//            tx_load/tx_byte           - load next transmit byte
//            spi_miso                  - current transmit bit
//            cs_active                 - synchronised inverse of cs_n
//            byte_valid/rx_byte        - one-clk strobe per completed byte
// Revision : 1.0 - initial release
// ============================================================================
module spi_tgt_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       spi_miso,
    output logic       cs_active,
    output logic       byte_valid,
    output logic [7:0] rx_byte
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_rx;
    logic [7:0]             r_tx;
    logic                   r_byte_valid;

    logic w_sck;
    logic w_mosi;
    logic w_sck_rise;
    logic w_sck_fall;

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign cs_active  = ~r_cs_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;

    assign spi_miso   = r_tx[7];
    assign byte_valid = r_byte_valid;
    // r_rx holds the complete byte for as long as byte_valid is high and
    // stays stable until the next SCK rise.
    assign rx_byte    = r_rx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sck_sync   <= '0;
            r_cs_sync    <= '1;
            r_mosi_sync  <= '0;
            r_sck_prev   <= 1'b0;
            r_bitcnt     <= 3'd0;
            r_rx         <= 8'h00;
            r_tx         <= 8'h00;
            r_byte_valid <= 1'b0;
        end else begin
            r_sck_sync   <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync  <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sck_prev   <= w_sck;
            r_byte_valid <= 1'b0;
            if (!cs_active) begin
                // Deselect discards any partial byte and idles MISO low.
                r_bitcnt <= 3'd0;
                r_tx     <= 8'h00;
            end else begin
                if (w_sck_rise) begin
                    r_rx     <= {r_rx[6:0], w_mosi};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        r_byte_valid <= 1'b1;
                    end
                end
                // The falling edge that follows the 8th rise belongs to the
                // next byte whose MSB is already presented, so only shift
                // while a byte is partly received.
                if (tx_load) begin
                    r_tx <= tx_byte;
                end else if (w_sck_fall && (r_bitcnt != 3'd0)) begin
                    r_tx <= {r_tx[6:0], 1'b0};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_dbg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_dbg_bridge
// Purpose  : SPI mode-0 target giving an external host read/write access to
//            the 6502 memory map. Acts as a second bus initiator via a
//            bus_req/bus_gnt handshake.
// Ports    : clk, reset (async, active low)
//            spi_sck, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe - SPI link
//            bus_req, bus_gnt, bus_ab, bus_we, bus_do, bus_di    - 6502 bus
//            err        - sticky overrun flag
//            cpu_halt   - host-controlled CPU freeze (DBG_HALT_EN only)
// Options  : define DBG_HALT_EN to add cpu_halt and opcodes 8'h10/8'h11.
// Revision : 1.0 - initial release
// ============================================================================
module spi_dbg_bridge
    import spi_dbg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_WRITE   = C_CMD_WRITE,
    parameter logic [7:0] CMD_READ    = C_CMD_READ
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] bus_ab,
    output logic        bus_we,
    output logic [7:0]  bus_do,
    input  logic [7:0]  bus_di,
    output logic        err
`ifdef DBG_HALT_EN
    ,
    output logic        cpu_halt
`endif
);

    logic       w_cs_active;
    logic       w_byte_valid;
    logic [7:0] w_rx_byte;
    logic [7:0] w_rd_value;

    frame_state_t r_frame;
    logic [15:0]  r_addr;
    logic         r_is_read;
    logic         r_tx_load;
    logic [7:0]   r_tx_byte;
    logic         r_launch;
    logic         r_launch_we;
    logic [15:0]  r_launch_addr;
    logic [7:0]   r_launch_data;

    bus_state_t   r_bus;
    logic         r_op_we;
    logic [15:0]  r_op_addr;
    logic [7:0]   r_op_data;
    logic [7:0]   r_rdata;
    logic         r_rd_drop;

    spi_tgt_shifter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .tx_load    (r_tx_load),
        .tx_byte    (r_tx_byte),
        .spi_miso   (spi_miso),
        .cs_active  (w_cs_active),
        .byte_valid (w_byte_valid),
        .rx_byte    (w_rx_byte)
    );

    assign spi_miso_oe = w_cs_active;

    // A read whose launch was dropped by an overrun returns the fill pattern.
    assign w_rd_value = r_rd_drop ? C_OVERRUN : r_rdata;

    // ------------------------------------------------------------------
    // Frame FSM: decodes the byte stream, chooses the next MISO byte and
    // issues bus launches. Every completed byte reloads the TX shifter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame       <= F_IDLE;
            r_addr        <= 16'h0000;
            r_is_read     <= 1'b0;
            r_tx_load     <= 1'b0;
            r_tx_byte     <= 8'h00;
            r_launch      <= 1'b0;
            r_launch_we   <= 1'b0;
            r_launch_addr <= 16'h0000;
            r_launch_data <= 8'h00;
`ifdef DBG_HALT_EN
            cpu_halt      <= 1'b0;
`endif
        end else begin
            r_tx_load <= 1'b0;
            r_launch  <= 1'b0;
            if (!w_cs_active) begin
                r_frame <= F_IDLE;
            end else if (w_byte_valid) begin
                r_tx_load <= 1'b1;
                r_tx_byte <= 8'h00;
                case (r_frame)
                    F_IDLE: begin
                        if (w_rx_byte == CMD_WRITE) begin
                            r_is_read <= 1'b0;
                            r_frame   <= F_ADDR_H;
                        end else if (w_rx_byte == CMD_READ) begin
                            r_is_read <= 1'b1;
                            r_frame   <= F_ADDR_H;
`ifdef DBG_HALT_EN
                        end else if (w_rx_byte == C_CMD_HALT) begin
                            cpu_halt  <= 1'b1;
                            r_frame   <= F_IGNORE;
                        end else if (w_rx_byte == C_CMD_RUN) begin
                            cpu_halt  <= 1'b0;
                            r_frame   <= F_IGNORE;
`endif
                        end else begin
                            r_frame   <= F_IGNORE;
                        end
                    end
                    F_ADDR_H: begin
                        r_addr[15:8] <= w_rx_byte;
                        r_frame      <= F_ADDR_L;
                    end
                    F_ADDR_L: begin
                        r_addr[7:0] <= w_rx_byte;
                        if (r_is_read) begin
                            // Prefetch the first location while the dummy
                            // byte is clocked out.
                            r_launch      <= 1'b1;
                            r_launch_we   <= 1'b0;
                            r_launch_addr <= {r_addr[15:8], w_rx_byte};
                            r_frame       <= F_DUMMY;
                        end else begin
                            r_frame       <= F_WDATA;
                        end
                    end
                    F_WDATA: begin
                        r_launch      <= 1'b1;
                        r_launch_we   <= 1'b1;
                        r_launch_addr <= r_addr;
                        r_launch_data <= w_rx_byte;
                        r_addr        <= r_addr + 16'd1;
                    end
                    F_DUMMY, F_RDATA: begin
                        // Present the prefetched byte and fetch the one after.
                        r_tx_byte     <= w_rd_value;
                        r_launch      <= 1'b1;
                        r_launch_we   <= 1'b0;
                        r_launch_addr <= r_addr + 16'd1;
                        r_addr        <= r_addr + 16'd1;
                        r_frame       <= F_RDATA;
                    end
                    F_IGNORE: begin
                        r_frame <= F_IGNORE;
                    end
                    default: begin
                        r_frame <= F_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus FSM: one operation at a time. Runs independently of chip select
    // so an accepted operation always completes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bus     <= B_IDLE;
            r_op_we   <= 1'b0;
            r_op_addr <= 16'h0000;
            r_op_data <= 8'h00;
            r_rdata   <= 8'h00;
            r_rd_drop <= 1'b0;
            bus_req   <= 1'b0;
            bus_ab    <= 16'h0000;
            bus_we    <= 1'b0;
            bus_do    <= 8'h00;
            err       <= 1'b0;
        end else begin
            bus_we <= 1'b0;
            if (r_launch && (r_bus != B_IDLE)) begin
                err <= 1'b1;
                if (!r_launch_we) begin
                    r_rd_drop <= 1'b1;
                end
            end
            case (r_bus)
                B_IDLE: begin
                    if (r_launch) begin
                        r_op_we   <= r_launch_we;
                        r_op_addr <= r_launch_addr;
                        r_op_data <= r_launch_data;
                        bus_req   <= 1'b1;
                        r_bus     <= B_REQ;
                        if (!r_launch_we) begin
                            r_rd_drop <= 1'b0;
                        end
                    end
                end
                B_REQ: begin
                    if (bus_gnt) begin
                        bus_ab <= r_op_addr;
                        bus_we <= r_op_we;
                        if (r_op_we) begin
                            bus_do <= r_op_data;
                        end
                        r_bus <= B_CYC;
                    end
                end
                B_CYC: begin
                    if (r_op_we) begin
                        bus_req <= 1'b0;
                        r_bus   <= B_IDLE;
                    end else begin
                        r_bus   <= B_CAP;
                    end
                end
                B_CAP: begin
                    r_rdata <= bus_di;
                    bus_req <= 1'b0;
                    r_bus   <= B_IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    r_bus   <= B_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_dbg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_dbg_bridge
// Purpose  : Self-checking bench for spi_dbg_bridge: directed frames plus
//            randomized frames compared against a frame-level reference
//            model (expected bus writes and MISO bytes).
// Options  : DBG_HALT_EN adds cpu_halt frame checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_dbg_bridge;

    localparam int HALF = 8;

    logic        clk;
    logic        reset;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] bus_ab;
    logic        bus_we;
    logic [7:0]  bus_do;
    logic [7:0]  bus_di;
    logic        err;
`ifdef DBG_HALT_EN
    logic        cpu_halt;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem     [65536];
    logic [7:0]  ref_mem [65536];
    logic [23:0] wr_q[$];
    int          req_cnt = 0;
    logic        req_prev = 1'b0;
    int          we_run = 0;
    logic        we_wide = 1'b0;
    logic        gnt_hold = 1'b0;
    int          gnt_dly = 0;

    spi_dbg_bridge u_dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .bus_ab      (bus_ab),
        .bus_we      (bus_we),
        .bus_do      (bus_do),
        .bus_di      (bus_di),
        .err         (err)
`ifdef DBG_HALT_EN
        ,
        .cpu_halt    (cpu_halt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Synchronous memory: bus_di valid one clk after bus_ab is presented.
    always @(posedge clk) begin
        if (bus_we) mem[bus_ab] <= bus_do;
        bus_di <= mem[bus_ab];
    end

    // Bus monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus_we) wr_q.push_back({bus_ab, bus_do});
        if (bus_we) we_run = we_run + 1;
        else        we_run = 0;
        if (we_run > 1) we_wide = 1'b1;
        if (bus_req && !req_prev) req_cnt = req_cnt + 1;
        req_prev = bus_req;
    end

    // Grant responder: random 0..3 clk latency unless forced low.
    initial begin
        bus_gnt = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt_hold || !bus_req) begin
                bus_gnt = 1'b0;
                if (!bus_req) gnt_dly = $urandom_range(0, 3);
            end else if (!bus_gnt) begin
                if (gnt_dly == 0) bus_gnt = 1'b1;
                else              gnt_dly = gnt_dly - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = spi_miso;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame_begin();
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    // Runs one complete frame of n bytes (first byte in the most
    // significant used byte of 'bytes') and checks it against the model.
    task automatic run_frame(input int n, input logic [63:0] bytes);
        logic [7:0]  b     [8];
        logic [7:0]  exp_m [8];
        logic [23:0] exp_wr[$];
        logic [15:0] a;
        logic [7:0]  r;
        int          req0;
        for (int i = 0; i < 8; i++) begin
            b[i]     = (i < n) ? bytes[8*(n-1-i) +: 8] : 8'h00;
            exp_m[i] = 8'h00;
        end
        a = {b[1], b[2]};
        if (b[0] == 8'h02) begin
            for (int k = 3; k < n; k++) begin
                exp_wr.push_back({a, b[k]});
                ref_mem[a] = b[k];
                a = a + 16'd1;
            end
        end else if (b[0] == 8'h03) begin
            for (int k = 4; k < n; k++) begin
                exp_m[k] = ref_mem[a];
                a = a + 16'd1;
            end
        end
        wr_q.delete();
        req0 = req_cnt;
        frame_begin();
        chk("miso_oe_on", 32'(spi_miso_oe), 32'd1);
        for (int k = 0; k < n; k++) begin
            xfer(b[k], 8, r);
            chk($sformatf("miso[%0d] op%h", k, b[0]), 32'(r), 32'(exp_m[k]));
        end
        frame_end();
        chk("miso_oe_off", 32'(spi_miso_oe), 32'd0);
        chk("wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
            chk("wr_addr_data", 32'(wr_q[i]), 32'(exp_wr[i]));
        if (b[0] != 8'h02 && b[0] != 8'h03)
            chk("no_req", 32'(req_cnt - req0), 32'd0);
    endtask

    initial begin
        logic [7:0]  v8;
        logic [7:0]  rx;
        logic [7:0]  op;
        logic [63:0] v;
        int          n;

        for (int i = 0; i < 65536; i++) begin
            v8 = 8'($urandom);
            mem[i]     = v8;
            ref_mem[i] = v8;
        end
        reset    = 1'b0;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_miso",    32'(spi_miso),    32'd0);
        chk("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
        chk("rst_bus_req", 32'(bus_req),     32'd0);
        chk("rst_bus_we",  32'(bus_we),      32'd0);
        chk("rst_bus_ab",  32'(bus_ab),      32'd0);
        chk("rst_bus_do",  32'(bus_do),      32'd0);
        chk("rst_err",     32'(err),         32'd0);
`ifdef DBG_HALT_EN
        chk("rst_cpu_halt", 32'(cpu_halt),   32'd0);
`endif
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Write burst, wrap-around, read burst.
        run_frame(5, 64'h02_1234_AA_55);
        chk("we_one_clk", 32'(we_wide), 32'd0);
        run_frame(5, 64'h02_FFFF_11_22);
        mem[16'hF000] = 8'h4C; ref_mem[16'hF000] = 8'h4C;
        mem[16'hF001] = 8'h00; ref_mem[16'hF001] = 8'h00;
        run_frame(6, 64'h03_F000_00_00_00);

        // Abort mid data byte, then a read frame must still work.
        wr_q.delete();
        frame_begin();
        xfer(8'h02, 8, rx);
        xfer(8'h00, 8, rx);
        xfer(8'h20, 8, rx);
        xfer(8'hA5, 4, rx);
        frame_end();
        chk("abort_no_write", 32'(wr_q.size()), 32'd0);
        run_frame(5, 64'h03_0010_00_00);

        // Unknown opcode.
        run_frame(4, 64'h7E_12_34_56);

`ifdef DBG_HALT_EN
        run_frame(1, 64'h10);
        chk("cpu_halt_set", 32'(cpu_halt), 32'd1);
        run_frame(1, 64'h11);
        chk("cpu_halt_clr", 32'(cpu_halt), 32'd0);
`endif

        // Randomized frames.
        for (int f = 0; f < 16; f++) begin
            n = $urandom_range(3, 8);
            case ($urandom_range(0, 2))
                0:       op = 8'h02;
                1:       op = 8'h03;
                default: begin
                    op = 8'($urandom);
                    if (op == 8'h02 || op == 8'h03) op = 8'h7E;
                end
            endcase
            v = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) v[8*(n-3) +: 16] = 16'hFFFE;
            v[8*(n-1) +: 8] = op;
            run_frame(n, v);
        end
        chk("we_one_clk_all", 32'(we_wide), 32'd0);
        chk("err_clean", 32'(err), 32'd0);

        // Grant delay: the write waits for the grant without error.
        wr_q.delete();
        gnt_hold = 1'b1;
        frame_begin();
        xfer(8'h02, 8, rx);
        xfer(8'h12, 8, rx);
        xfer(8'h34, 8, rx);
        xfer(8'hAA, 8, rx);
        repeat (8) @(negedge clk);
        chk("gnt_wait_req", 32'(bus_req), 32'd1);
        chk("gnt_wait_nowr", 32'(wr_q.size()), 32'd0);
        gnt_hold = 1'b0;
        repeat (12) @(negedge clk);
        chk("gnt_wr_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) chk("gnt_wr", 32'(wr_q[0]), 32'h1234AA);
        chk("gnt_err0", 32'(err), 32'd0);
        // Hold the grant across the next byte: second launch overruns.
        wr_q.delete();
        gnt_hold = 1'b1;
        xfer(8'h55, 8, rx);
        xfer(8'h66, 8, rx);
        repeat (8) @(negedge clk);
        gnt_hold = 1'b0;
        frame_end();
        chk("ovr_err", 32'(err), 32'd1);
        chk("ovr_wr_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) chk("ovr_wr", 32'(wr_q[0]), 32'h123555);

        // Asynchronous reset while a request is pending.
        gnt_hold = 1'b1;
        frame_begin();
        xfer(8'h02, 8, rx);
        xfer(8'h00, 8, rx);
        xfer(8'h40, 8, rx);
        xfer(8'h77, 8, rx);
        repeat (8) @(negedge clk);
        chk("arst_req_before", 32'(bus_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req", 32'(bus_req), 32'd0);
        chk("arst_we",  32'(bus_we),  32'd0);
        chk("arst_err", 32'(err),     32'd0);
        spi_cs_n = 1'b1;
        gnt_hold = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
